// File: rtl/datapath_sequencer_if.sv
// -----------------------------------------------------------------------------
// datapath_sequencer_if
// Groups the signals between the sequencer and its surroundings. These are the
// instruction fetch handshake, the datapath status/control, and the
// halted/illegal indicators.
//   master : the sequencer (drives fetch, controlword, immediate, halted, illegal)
//   slave  : instruction memory + datapath (drives instruction, valid, status)
// -----------------------------------------------------------------------------
interface datapath_sequencer_if;
    logic [31:0] instruction;
    logic        instruction_valid;
    logic [4:0]  status;
    logic        fetch;
    logic [30:0] controlword;
    logic [63:0] immediate;
    logic        halted;
    logic        illegal;

    modport master (
        input  instruction, instruction_valid, status,
        output fetch, controlword, immediate, halted, illegal
    );

    modport slave (
        output instruction, instruction_valid, status,
        input  fetch, controlword, immediate, halted, illegal
    );
endinterface

// File: rtl/datapath_sequencer.sv
// -----------------------------------------------------------------------------
// datapath_sequencer
// Multi-cycle control unit for the 64-bit datapath. It fetches an instruction
// through a valid-qualified handshake and latches it in IR. It then emits the
// datapath control word and immediate for EXEC, plus LDWB for loads. It stops
// in HALTED on HALT or an undefined opcode.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : master side of datapath_sequencer_if
//           in : instruction, instruction_valid, status[0] = live zero flag
//           out: fetch, controlword[30:0], immediate[63:0], halted, illegal
// -----------------------------------------------------------------------------
module datapath_sequencer #(
    parameter logic [4:0] ALU_ADD    = 5'b01000,
    parameter logic [4:0] ALU_PASS_A = 5'b00000,
    parameter logic [4:0] LINK_REG   = 5'd30
) (
    input  logic                    clock,
    input  logic                    reset,
    datapath_sequencer_if.master    bus
);

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_EXEC   = 2'd1;
    localparam logic [1:0] ST_LDWB   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    function automatic logic [63:0] sext18(input logic [17:0] v);
        return {{46{v[17]}}, v};
    endfunction

    function automatic logic [63:0] sext28(input logic [27:0] v);
        return {{36{v[27]}}, v};
    endfunction

    logic [1:0]  state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        halted_q, halted_d;
    logic        illegal_q, illegal_d;

    logic [3:0] op_s;
    logic [4:0] rd_s, rn_s, rm_s, fs_s;
    logic       s_s;

    assign op_s = ir_q[31:28];
    assign rd_s = ir_q[27:23];
    assign rn_s = ir_q[22:18];
    assign rm_s = ir_q[17:13];
    assign fs_s = ir_q[12:8];
    assign s_s  = ir_q[7];

    // Only the live zero flag steers sequencing; the registered flags are not used here.
    logic unused_status_s;
    assign unused_status_s = ^bus.status[4:1];

    // Control word fields.
    logic       alu_en_s, b_sel_s, rfb_en_s, rf_wr_s, ram_en_s, ram_wr_s;
    logic       pc_en_s, pc_in_s, st_ld_s;
    logic [4:0] alu_fs_s, sel_a_s, sel_b_s, wr_addr_s;
    logic [1:0] pc_fs_s;
    logic [63:0] imm_s;

    // Next-state, IR capture and sticky halted/illegal flags.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_FETCH: begin
                if (bus.instruction_valid) begin
                    state_d = ST_EXEC;
                    ir_d    = bus.instruction;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (op_s == 4'd3) begin
                    state_d = ST_LDWB;
                end else if (op_s >= 4'd10) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                    // 10..14 are undefined; 15 is a legitimate HALT.
                    if (op_s != 4'd15) begin
                        illegal_d = 1'b1;
                    end else begin
                        illegal_d = illegal_q;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_LDWB:   state_d = ST_FETCH;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_FETCH;
        endcase
    end

    // State, IR and status flag registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            ir_q      <= 32'd0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    // Decode IR into control word fields; all zero outside EXEC and LDWB.
    always_comb begin
        alu_en_s  = 1'b0;
        b_sel_s   = 1'b0;
        alu_fs_s  = 5'd0;
        rfb_en_s  = 1'b0;
        sel_a_s   = 5'd0;
        sel_b_s   = 5'd0;
        wr_addr_s = 5'd0;
        rf_wr_s   = 1'b0;
        ram_en_s  = 1'b0;
        ram_wr_s  = 1'b0;
        pc_en_s   = 1'b0;
        pc_fs_s   = 2'b00;
        pc_in_s   = 1'b0;
        st_ld_s   = 1'b0;
        imm_s     = 64'd0;
        if (state_q == ST_EXEC) begin
            case (op_s)
                4'd0: pc_fs_s = 2'b01;
                4'd1, 4'd2: begin
                    sel_a_s   = rn_s;
                    sel_b_s   = rm_s;
                    alu_en_s  = 1'b1;
                    wr_addr_s = rd_s;
                    rf_wr_s   = 1'b1;
                    st_ld_s   = s_s;
                    pc_fs_s   = 2'b01;
                    if (op_s == 4'd2) begin
                        b_sel_s  = 1'b1;
                        imm_s    = sext18(ir_q[17:0]);
                        alu_fs_s = ALU_ADD;
                    end else begin
                        alu_fs_s = fs_s;
                    end
                end
                // Address phase only; the register write happens in LDWB.
                4'd3: begin
                    sel_a_s  = rn_s;
                    b_sel_s  = 1'b1;
                    alu_fs_s = ALU_ADD;
                    imm_s    = sext18(ir_q[17:0]);
                    pc_fs_s  = 2'b00;
                end
                4'd4: begin
                    sel_a_s  = rn_s;
                    b_sel_s  = 1'b1;
                    alu_fs_s = ALU_ADD;
                    imm_s    = sext18(ir_q[17:0]);
                    sel_b_s  = rd_s;
                    rfb_en_s = 1'b1;
                    ram_wr_s = 1'b1;
                    pc_fs_s  = 2'b01;
                end
                4'd5, 4'd6: begin
                    imm_s   = sext28(ir_q[27:0]) << 2;
                    pc_in_s = 1'b1;
                    pc_fs_s = 2'b11;
                    // BL: the datapath puts PC+4 on the bus for the link write.
                    if (op_s == 4'd6) begin
                        pc_en_s   = 1'b1;
                        wr_addr_s = LINK_REG;
                        rf_wr_s   = 1'b1;
                    end else begin
                        pc_en_s   = 1'b0;
                    end
                end
                4'd7: begin
                    sel_a_s = rn_s;
                    pc_in_s = 1'b0;
                    pc_fs_s = 2'b10;
                end
                // CBZ/CBNZ: rn passes through the ALU so status[0] is its zero flag.
                4'd8, 4'd9: begin
                    sel_a_s  = rn_s;
                    alu_fs_s = ALU_PASS_A;
                    imm_s    = sext18(ir_q[17:0]) << 2;
                    pc_in_s  = 1'b1;
                    if (bus.status[0] == (op_s == 4'd8)) begin
                        pc_fs_s = 2'b11;
                    end else begin
                        pc_fs_s = 2'b01;
                    end
                end
                default: pc_fs_s = 2'b00;
            endcase
        end else if (state_q == ST_LDWB) begin
            sel_a_s   = rn_s;
            b_sel_s   = 1'b1;
            alu_fs_s  = ALU_ADD;
            imm_s     = sext18(ir_q[17:0]);
            ram_en_s  = 1'b1;
            wr_addr_s = rd_s;
            rf_wr_s   = 1'b1;
            pc_fs_s   = 2'b01;
        end else begin
            pc_fs_s   = 2'b00;
        end
    end

    assign bus.fetch       = (state_q == ST_FETCH);
    assign bus.controlword = {alu_en_s, b_sel_s, alu_fs_s, rfb_en_s, sel_a_s, sel_b_s,
                              wr_addr_s, rf_wr_s, ram_en_s, ram_wr_s, pc_en_s, pc_fs_s,
                              pc_in_s, st_ld_s};
    assign bus.immediate   = imm_s;
    assign bus.halted      = halted_q;
    assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// -----------------------------------------------------------------------------
// tb_datapath_sequencer
// Directed bench for datapath_sequencer. Expected EXEC/LDWB control words are
// pushed to a scoreboard when an instruction is presented. They are popped and
// compared when the sequencer reaches that cycle.
// -----------------------------------------------------------------------------
module tb_datapath_sequencer;

    localparam logic [4:0] ADD  = 5'b01000;
    localparam logic [4:0] PASS = 5'b00000;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    datapath_sequencer_if bus();

    datapath_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct {
        string       tag;
        logic [30:0] cw;
        logic [63:0] imm;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [30:0] mk_cw(
        input logic alu_en, input logic b_sel, input logic [4:0] fs, input logic rfb,
        input logic [4:0] sa, input logic [4:0] sbs, input logic [4:0] wa,
        input logic rfw, input logic ram_en, input logic ram_wr, input logic pc_en,
        input logic [1:0] pc_fs, input logic pc_in, input logic st_ld);
        return {alu_en, b_sel, fs, rfb, sa, sbs, wa, rfw, ram_en, ram_wr, pc_en,
                pc_fs, pc_in, st_ld};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input string tag, input logic [30:0] cw, input logic [63:0] imm);
        exp_t e;
        e.tag = tag;
        e.cw  = cw;
        e.imm = imm;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL sb_empty: observed 0 entries expected >0");
        end else begin
            n_cmp--;
            e = sb.pop_front();
            check({e.tag, "_cw"}, {33'd0, bus.controlword}, {33'd0, e.cw});
            check({e.tag, "_imm"}, bus.immediate, e.imm);
        end
    endtask

    // Present one instruction in FETCH, then compare the EXEC cycle.
    task automatic issue(input string tag, input logic [31:0] instr,
                         input logic [30:0] cw, input logic [63:0] imm);
        check({tag, "_fetch"}, {63'd0, bus.fetch}, 64'd1);
        bus.instruction       = instr;
        bus.instruction_valid = 1'b1;
        push(tag, cw, imm);
        tick();
        bus.instruction_valid = 1'b0;
        bus.instruction       = 32'hA5A5_A5A5;
        check({tag, "_exec_fetch"}, {63'd0, bus.fetch}, 64'd1 - 64'd1);
        pop_check();
    endtask

    logic [31:0] ldur_w;

    initial begin
        reset                 = 1'b0;
        bus.instruction       = 32'd0;
        bus.instruction_valid = 1'b0;
        bus.status            = 5'd0;
        #1;
        check("rst_fetch",   {63'd0, bus.fetch}, 64'd1);
        check("rst_cw",      {33'd0, bus.controlword}, 64'd0);
        check("rst_imm",     bus.immediate, 64'd0);
        check("rst_halted",  {63'd0, bus.halted}, 64'd0);
        check("rst_illegal", {63'd0, bus.illegal}, 64'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        check("rel_fetch", {63'd0, bus.fetch}, 64'd1);
        check("rel_cw",    {33'd0, bus.controlword}, 64'd0);

        // NOP: two cycles, PC+4 in EXEC.
        issue("nop", 32'h0000_0000, mk_cw(0,0,5'd0,0,5'd0,5'd0,5'd0,0,0,0,0,2'b01,0,0), 64'd0);
        tick();
        check("nop_2cyc", {63'd0, bus.fetch}, 64'd1);

        // ALUR rd=7 rn=8 rm=9 fs=10101 S=0.
        issue("alur", {4'd1, 5'd7, 5'd8, 5'd9, 5'b10101, 1'b0, 7'd0},
              mk_cw(1,0,5'b10101,0,5'd8,5'd9,5'd7,1,0,0,0,2'b01,0,0), 64'd0);
        tick();

        // ADDI rd=3 rn=1 imm=-4 (rm field is 31, S bit is 1 from the immediate).
        issue("addi", {4'd2, 5'd3, 5'd1, 18'h3FFFC},
              mk_cw(1,1,ADD,0,5'd1,5'd31,5'd3,1,0,0,0,2'b01,0,1), 64'hFFFF_FFFF_FFFF_FFFC);
        tick();

        // LDUR rd=2 rn=5 imm=8: EXEC, LDWB, three cycles total.
        ldur_w = {4'd3, 5'd2, 5'd5, 18'd8};
        push("ldur", mk_cw(0,1,ADD,0,5'd5,5'd0,5'd0,0,0,0,0,2'b00,0,0), 64'd8);
        push("ldwb", mk_cw(0,1,ADD,0,5'd5,5'd0,5'd2,1,1,0,0,2'b01,0,0), 64'd8);
        bus.instruction = ldur_w;
        bus.instruction_valid = 1'b1;
        tick();
        bus.instruction_valid = 1'b0;
        pop_check();
        tick();
        check("ldwb_fetch", {63'd0, bus.fetch}, 64'd0);
        pop_check();
        tick();
        check("ldur_3cyc", {63'd0, bus.fetch}, 64'd1);

        // STUR rd=6 rn=2 imm=16.
        issue("stur", {4'd4, 5'd6, 5'd2, 18'd16},
              mk_cw(0,1,ADD,1,5'd2,5'd6,5'd0,0,0,1,0,2'b01,0,0), 64'd16);
        tick();

        // B imm28=5 -> byte offset 20.
        issue("b", {4'd5, 28'd5}, mk_cw(0,0,5'd0,0,5'd0,5'd0,5'd0,0,0,0,0,2'b11,1,0), 64'd20);
        tick();

        // BL imm28=-1 -> -4, link into register 30.
        issue("bl", {4'd6, 28'hFFF_FFFF},
              mk_cw(0,0,5'd0,0,5'd0,5'd0,5'd30,1,0,0,1,2'b11,1,0), 64'hFFFF_FFFF_FFFF_FFFC);
        tick();

        // BR rn=11.
        issue("br", {4'd7, 5'd0, 5'd11, 18'd0}, mk_cw(0,0,5'd0,0,5'd11,5'd0,5'd0,0,0,0,0,2'b10,0,0), 64'd0);
        tick();

        // CBZ/CBNZ rn=4 imm=3 under both zero-flag values.
        for (int k = 0; k < 4; k++) begin
            logic       is_cbnz;
            logic       z;
            logic [1:0] pcfs;
            is_cbnz    = k[1];
            z          = k[0];
            pcfs       = ((z == 1'b1) != is_cbnz) ? 2'b11 : 2'b01;
            bus.status = {4'b1010, z};
            issue(is_cbnz ? (z ? "cbnz_z1" : "cbnz_z0") : (z ? "cbz_z1" : "cbz_z0"),
                  {(is_cbnz ? 4'd9 : 4'd8), 5'd0, 5'd4, 18'd3},
                  mk_cw(0,0,PASS,0,5'd4,5'd0,5'd0,0,0,0,0,pcfs,1,0), 64'd12);
            tick();
        end
        bus.status = 5'd0;

        // Instruction held without valid for three cycles is never latched.
        bus.instruction = {4'd1, 5'd7, 5'd8, 5'd9, 5'b10101, 1'b1, 7'd0};
        for (int k = 0; k < 3; k++) begin
            check("novalid_cw", {33'd0, bus.controlword}, 64'd0);
            check("novalid_fetch", {63'd0, bus.fetch}, 64'd1);
            tick();
        end
        issue("nop2", 32'h0000_0000, mk_cw(0,0,5'd0,0,5'd0,5'd0,5'd0,0,0,0,0,2'b01,0,0), 64'd0);
        tick();

        // Reset asserted during LDWB aborts it immediately.
        push("ldur_r", mk_cw(0,1,ADD,0,5'd5,5'd0,5'd0,0,0,0,0,2'b00,0,0), 64'd8);
        push("ldwb_r", mk_cw(0,1,ADD,0,5'd5,5'd0,5'd2,1,1,0,0,2'b01,0,0), 64'd8);
        bus.instruction = ldur_w;
        bus.instruction_valid = 1'b1;
        tick();
        bus.instruction_valid = 1'b0;
        pop_check();
        tick();
        pop_check();
        reset = 1'b0;
        #1;
        check("abort_cw",    {33'd0, bus.controlword}, 64'd0);
        check("abort_fetch", {63'd0, bus.fetch}, 64'd1);
        tick();
        reset = 1'b1;
        tick();
        check("abort_rel_fetch", {63'd0, bus.fetch}, 64'd1);

        // Undefined opcode 12: illegal + halted, then no more fetches.
        issue("op12", {4'd12, 28'd0}, 31'd0, 64'd0);
        check("op12_exec_halted", {63'd0, bus.halted}, 64'd0);
        tick();
        check("op12_halted",  {63'd0, bus.halted}, 64'd1);
        check("op12_illegal", {63'd0, bus.illegal}, 64'd1);
        check("op12_fetch",   {63'd0, bus.fetch}, 64'd0);
        bus.instruction = 32'd0;
        bus.instruction_valid = 1'b1;
        tick(); tick();
        check("halt_stay_fetch", {63'd0, bus.fetch}, 64'd0);
        check("halt_stay_cw",    {33'd0, bus.controlword}, 64'd0);
        bus.instruction_valid = 1'b0;

        // Reset clears sticky flags; a real HALT sets halted only.
        reset = 1'b0;
        #1;
        check("rst2_illegal", {63'd0, bus.illegal}, 64'd0);
        check("rst2_halted",  {63'd0, bus.halted}, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        issue("halt", {4'd15, 28'd0}, 31'd0, 64'd0);
        tick();
        check("halt_halted",  {63'd0, bus.halted}, 64'd1);
        check("halt_illegal", {63'd0, bus.illegal}, 64'd0);
        check("halt_fetch",   {63'd0, bus.fetch}, 64'd0);

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_bad++;
            $error("FAIL sb_leftover: observed %0d expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
